fx_kpad: RTL
============

// Module: fx_kpad
// PURPOSE
//  PC-FX K-port joypad responder: the pad-side end of the K-port link that
//  the gate array's KPC unit initiates.
//  Snapshots button state on host LATCH, then shifts a 32-bit pad word out on
//  KDI, one bit per host KCLK rising edge, LSB first. Sits between the
//  MiSTer input bridge (BTN) and the gate array K-port pins, in the CLK domain.
// PARAMETERS
//  PAD_ID       4'hF  pad type ID placed in word bits [31:28] (F = std joypad)
//  SYNC_STAGES  2     synchroniser depth on KCLK/KLATCH (>=2)
//  WORD_BITS    32    bits per transfer (fixed 32 in PC-FX; counter sized from it)
// PORTS
//  CLK        in   1   system clock
//  RES        in   1   asynchronous reset, active-high
//  CE         in   1   clock enable; all state frozen while low
//  BTN        in   16  buttons, 1=pressed: [0]I [1]II [2]III [3]IV [4]V [5]VI
//                      [6]SEL [7]RUN [8]UP [9]RIGHT [10]DOWN [11]LEFT [12]MODE1
//                      [14]MODE2 [13],[15] reserved (passed through)
//  KCLK       in   1   host serial clock, idle high, may be asynchronous
//  KLATCH     in   1   host latch/trigger, active-high, may be asynchronous
//  KDI        out  1   serial data to host (idle 1)
//  BUSY       out  1   1 while in LATCH or SHIFT
//  XFER_DONE  out  1   one-CE pulse when last bit has been shifted past
// BEHAVIOUR
//  Reset (async, RES=1): state IDLE, KDI=1, BUSY=0, XFER_DONE=0, shift reg
//   all 1s, bit count 0, sync flops to idle (KCLK=1, KLATCH=0).
//  Input path: KCLK, KLATCH each pass SYNC_STAGES flops (CE-qualified); edge
//   detect on synced value vs. one-cycle-delayed copy. Pin-to-KDI latency =
//   SYNC_STAGES+1 CE cycles.
//  Pad word W = {PAD_ID, 12'h000, BTN}.
//  States:
//   IDLE  : KDI=1. KLATCH rise -> LATCH. KCLK edges ignored.
//   LATCH : shift reg <= W every CE cycle (transparent while latch high);
//           KDI = shift[0]; count=0. KLATCH fall -> SHIFT.
//   SHIFT : on KCLK rise: shift >>= 1 (MSB fill 1), count++, KDI = new shift[0].
//           When count reaches WORD_BITS -> DONE. KLATCH rise -> LATCH
//           (abort and reload, no XFER_DONE).
//   DONE  : KDI=1, XFER_DONE=1 for the single entry cycle, BUSY=0; then IDLE.
//           Extra KCLK edges beyond WORD_BITS keep KDI=1.
//  Simultaneous KLATCH rise and KCLK rise (same synced cycle): latch wins,
//   clock edge discarded.
//  KCLK falling edges have no effect. BTN changes after KLATCH fall do not
//   alter the word in flight (snapshot).
//  Count width = $clog2(WORD_BITS+1); no wrap: saturates into DONE.
//  Reset asserted mid-SHIFT: immediate return to reset values; next transfer
//   requires a fresh KLATCH rise.
//  CE=0: sync flops, state, count, outputs hold; edges are only seen on CE.
// TESTING
//  1 BTN=16'h0081, latch pulse, 32 KCLK rises -> KDI bits reconstruct
//    32'hF0000081 LSB first; XFER_DONE pulses once; BUSY 1->0.
//  2 Change BTN to 16'hFFFF after KLATCH fall -> shifted word still 32'hF0000081.
//  3 Latch after 10 clocks of a transfer with BTN=16'h0100 -> count restarts,
//    full word 32'hF0000100 read, no XFER_DONE for aborted transfer.
//  4 40 KCLK rises after one latch -> bits 32..39 read 1; single XFER_DONE.
//  5 RES pulsed after 5 bits -> KDI=1, BUSY=0 at once; KCLK alone does
//    nothing until next latch.
//  6 KCLK and KLATCH rise in same cycle, CE toggling 1/0 -> first KDI bit is
//    W[0]; pin-to-KDI delay = SYNC_STAGES+1 CE cycles.

Source files
------------

// File: rtl/fx_kpad_if.sv
`default_nettype none
// ============================================================================
//  Module      : fx_kpad_if
//  Description : K-port link bundle between the pad responder and the host
//                side (gate array KPC pins plus the button bridge).
//                  BTN        [15:0]  button state, 1 = pressed
//                  KCLK               host serial clock, idle high
//                  KLATCH             host latch/trigger, active high
//                  KDI                serial data back to host, idle high
//                  BUSY               pad is latching or shifting
//                  XFER_DONE          one-CE pulse after the last bit
//                master = host side, slave = pad responder.
//  Revision    : 1.0  initial release
// ============================================================================
interface fx_kpad_if;
    logic [15:0] BTN;
    logic        KCLK;
    logic        KLATCH;
    logic        KDI;
    logic        BUSY;
    logic        XFER_DONE;

    modport master (
        output BTN,
        output KCLK,
        output KLATCH,
        input  KDI,
        input  BUSY,
        input  XFER_DONE
    );

    modport slave (
        input  BTN,
        input  KCLK,
        input  KLATCH,
        output KDI,
        output BUSY,
        output XFER_DONE
    );
endinterface
`default_nettype wire

// File: rtl/fx_kpad.sv
`default_nettype none
// ============================================================================
//  Module      : fx_kpad
//  Description : PC-FX K-port joypad responder. Snapshots the button word on
//                a host latch, then shifts it out LSB first on KDI, one bit
//                per synchronised KCLK rising edge.
//  Ports       : CLK    system clock
//                RES    asynchronous reset, active high
//                CE     clock enable, all state frozen while low
//                kport  fx_kpad_if.slave (BTN, KCLK, KLATCH in;
//                       KDI, BUSY, XFER_DONE out)
//  Parameters  : PAD_ID       pad type ID in word bits [31:28]
//                SYNC_STAGES  synchroniser depth on KCLK/KLATCH (>= 2)
//                WORD_BITS    bits per transfer
//  Revision    : 1.0  initial release
// ============================================================================
module fx_kpad #(
    parameter logic [3:0] PAD_ID      = 4'hF,
    parameter int         SYNC_STAGES = 2,
    parameter int         WORD_BITS   = 32
) (
    input  wire logic  CLK,
    input  wire logic  RES,
    input  wire logic  CE,
    fx_kpad_if.slave   kport
);

    localparam int                 c_cnt_w   = $clog2(WORD_BITS + 1);
    localparam logic [c_cnt_w-1:0] c_last_m1 = c_cnt_w'(WORD_BITS - 1);
    localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_latch = 2'd1;
    localparam logic [1:0] c_st_shift = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    // ------------------------------------------------------------------
    // Input synchronisers and edge detection. Flops reset to the idle
    // levels of the link so reset never manufactures a spurious edge.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_kclk_sync;
    logic [SYNC_STAGES-1:0] r_klat_sync;
    logic                   r_kclk_d;
    logic                   r_klat_d;

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_kclk_sync <= '1;
            r_klat_sync <= '0;
            r_kclk_d    <= 1'b1;
            r_klat_d    <= 1'b0;
        end else if (CE) begin
            r_kclk_sync <= {r_kclk_sync[SYNC_STAGES-2:0], kport.KCLK};
            r_klat_sync <= {r_klat_sync[SYNC_STAGES-2:0], kport.KLATCH};
            r_kclk_d    <= r_kclk_sync[SYNC_STAGES-1];
            r_klat_d    <= r_klat_sync[SYNC_STAGES-1];
        end
    end

    logic w_kclk_rise;
    logic w_klat_rise;
    logic w_klat_fall;

    assign w_kclk_rise =  r_kclk_sync[SYNC_STAGES-1] & ~r_kclk_d;
    assign w_klat_rise =  r_klat_sync[SYNC_STAGES-1] & ~r_klat_d;
    assign w_klat_fall = ~r_klat_sync[SYNC_STAGES-1] &  r_klat_d;

    // ------------------------------------------------------------------
    // Pad word and transfer engine
    // ------------------------------------------------------------------
    logic [WORD_BITS-1:0] w_word;
    assign w_word = WORD_BITS'({PAD_ID, 12'h000, kport.BTN});

    logic [1:0]           r_state;
    logic [WORD_BITS-1:0] r_shift;
    logic [c_cnt_w-1:0]   r_count;

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_state <= c_st_idle;
            r_shift <= '1;
            r_count <= '0;
        end else if (CE) begin
            case (r_state)
                c_st_idle: begin
                    // Load on the entry edge so KDI shows W[0] in the very
                    // first LATCH cycle rather than one cycle later.
                    if (w_klat_rise) begin
                        r_state <= c_st_latch;
                        r_shift <= w_word;
                        r_count <= '0;
                    end
                end
                c_st_latch: begin
                    // Transparent while latch is high; the value present on
                    // the falling-edge cycle is the snapshot that is shifted.
                    r_shift <= w_word;
                    r_count <= '0;
                    if (w_klat_fall) begin
                        r_state <= c_st_shift;
                    end
                end
                c_st_shift: begin
                    // Latch has priority: a coincident clock edge is dropped.
                    if (w_klat_rise) begin
                        r_state <= c_st_latch;
                        r_shift <= w_word;
                        r_count <= '0;
                    end else if (w_kclk_rise) begin
                        r_shift <= {1'b1, r_shift[WORD_BITS-1:1]};
                        r_count <= r_count + c_one;
                        if (r_count == c_last_m1) begin
                            r_state <= c_st_done;
                        end
                    end
                end
                c_st_done: begin
                    // A latch landing on the single DONE cycle is honoured
                    // instead of being lost on the way back to IDLE.
                    if (w_klat_rise) begin
                        r_state <= c_st_latch;
                        r_shift <= w_word;
                        r_count <= '0;
                    end else begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs are decoded from registered state only, so they hold with CE.
    // ------------------------------------------------------------------
    logic w_active;
    assign w_active        = (r_state == c_st_latch) || (r_state == c_st_shift);
    assign kport.KDI       = w_active ? r_shift[0] : 1'b1;
    assign kport.BUSY      = w_active;
    assign kport.XFER_DONE = (r_state == c_st_done);

endmodule
`default_nettype wire
